bit_serial_adder: RTL and testbench

//  Sequential driver/consumer for the LUT-based 1-bit full adder (Q3_MIX_LUTS).

---
 rtl/bit_serial_pkg.sv | 33 +++
 rtl/bit_serial_adder_fa.sv | 18 +
 rtl/bit_serial_adder.sv | 135 +++++++++++++
 tb/tb_bit_serial_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial adder and its LUT full adder.
package bit_serial_pkg;

  // Default operand/sum width.
  localparam int BS_WIDTH_DEF = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } bs_state_t;

  // Full-adder truth tables. The index is {A, B, CIN}.
  // Sum is the parity of the three inputs.
  localparam logic [7:0] FA_SUM_LUT  = 8'b1001_0110;
  // Carry is the majority of the three inputs.
  localparam logic [7:0] FA_COUT_LUT = 8'b1110_1000;

  // Ripple incrementer built from XOR/AND gates. The full adder is the only
  // arithmetic block in the design, so the bit counter does not use an adder.
  function automatic logic [31:0] bs_incr(input logic [31:0] x);
    logic [31:0] y;
    logic        carry;
    carry = 1'b1;
    for (int i = 0; i < 32; i++) begin
      y[i]  = x[i] ^ carry;
      carry = carry & x[i];
    end
    return y;
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Q3_MIX_LUTS: 1-bit full adder implemented as two 3-input lookup tables.
module Q3_MIX_LUTS
  import bit_serial_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic COUT
);

  logic [2:0] w_idx;

  assign w_idx = {A, B, CIN};
  assign S     = FA_SUM_LUT[w_idx];
  assign COUT  = FA_COUT_LUT[w_idx];

endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// by driving a single LUT full adder. Start/done handshake; one job at a time.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  bs_state_t r_state;
  bs_state_t w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic [CW-1:0]    w_count_inc;

  // The one and only adder: sees the current LSBs and the running carry.
  Q3_MIX_LUTS u_fa (
    .A    (r_a_sr[0]),
    .B    (r_b_sr[0]),
    .CIN  (r_carry),
    .S    (w_s),
    .COUT (w_cout)
  );

  assign w_last      = (r_count == LAST_COUNT);
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_sum_next  = WIDTH'({w_s, r_sum_sr} >> 1);
  assign w_count_inc = CW'(bs_incr(32'(r_count)));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Operand/sum shift registers, carry and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
    end else if (w_load) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_carry  <= cin_init;
      r_count  <= '0;
    end else if (w_shift) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_next;
      r_carry  <= w_cout;
      // Wrap to zero on the last bit so the counter never exceeds WIDTH-1.
      r_count  <= w_last ? '0 : w_count_inc;
    end
  end

  // Result registers: updated only on the final shift, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_shift && w_last) begin
      r_sum  <= w_sum_next;
      r_cout <= w_cout;
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8). Expected results come
// from plain integer addition of the operands.
module tb_bit_serial_adder;

  localparam int W   = 8;
  localparam int LAT = W + 1;   // start edge to done, in cycles
  localparam int GAP = W + 2;   // spacing of jobs with start held high

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin_init;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin_init (cin_init),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Issue one job and observe it until done (bounded). Reports measurements only.
  task automatic run_job(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output logic [W:0] res, output int lat, output int busy_cnt,
                         output logic done_after, output logic busy_after);
    a = xa; b = xb; cin_init = xc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
    res = {cout, sum};
    tick();
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin_init = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, expected all 0",
               busy, done, cout, sum);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_zero();
    logic [W:0] res;
    int lat, bcnt;
    logic d_after, b_after;
    run_job(8'h00, 8'h00, 1'b0, res, lat, bcnt, d_after, b_after);
    n_tests++;
    if (res !== model(8'h00, 8'h00, 1'b0)) begin
      n_fail++;
      $display("FAIL zero_sum: got %h expected %h", res, model(8'h00, 8'h00, 1'b0));
    end
    n_tests++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d expected %0d", lat, LAT);
    end
    n_tests++;
    if (bcnt !== LAT) begin
      n_fail++;
      $display("FAIL zero_busy_cycles: got %0d expected %0d", bcnt, LAT);
    end
    n_tests++;
    if (d_after !== 1'b0 || b_after !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_width: got done=%b busy=%b after pulse, expected 0 0",
               d_after, b_after);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         vc[3];
    logic [W:0]   res;
    int lat, bcnt;
    logic d_after, b_after;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0;
    va[1] = 8'hA5; vb[1] = 8'h5A; vc[1] = 1'b1;
    va[2] = 8'h7F; vb[2] = 8'h01; vc[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_job(va[i], vb[i], vc[i], res, lat, bcnt, d_after, b_after);
      n_tests++;
      if (res !== model(va[i], vb[i], vc[i])) begin
        n_fail++;
        $display("FAIL vector%0d_sum: got %h expected %h", i, res, model(va[i], vb[i], vc[i]));
      end
      n_tests++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL vector%0d_latency: got %0d expected %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [W:0] exp_res;
    int lat, extra_done;
    exp_res = model(8'h3C, 8'h41, 1'b1);
    a = 8'h3C; b = 8'h41; cin_init = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'hFF; cin_init = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0; cin_init = 1'b0;
    lat = 4;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL busy_start_latency: got %0d expected %0d", lat, LAT);
    end
    n_tests++;
    if ({cout, sum} !== exp_res) begin
      n_fail++;
      $display("FAIL busy_start_result: got %h expected %h", {cout, sum}, exp_res);
    end
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) extra_done++;
    end
    n_tests++;
    if (extra_done !== 0) begin
      n_fail++;
      $display("FAIL busy_start_extra_done: got %0d pulses expected 0", extra_done);
    end
  endtask

  task automatic test_reset_mid_job();
    logic [W:0] res;
    int lat, bcnt, seen_done;
    logic d_after, b_after;
    a = 8'h12; b = 8'h34; cin_init = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b cout=%b sum=%h, expected all 0",
               busy, done, cout, sum);
    end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen_done++;
    end
    n_tests++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d pulses expected 0", seen_done);
    end
    run_job(8'h9C, 8'h77, 1'b1, res, lat, bcnt, d_after, b_after);
    n_tests++;
    if (res !== model(8'h9C, 8'h77, 1'b1) || lat !== LAT) begin
      n_fail++;
      $display("FAIL midreset_fresh_job: got %h lat %0d expected %h lat %0d",
               res, lat, model(8'h9C, 8'h77, 1'b1), LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    logic [W:0] exp_now;
    logic [W:0] e;
    logic       idle_now;
    int accepted, completed, cyc, last_done;
    accepted = 0; completed = 0; cyc = 0; last_done = -1;
    a = W'($urandom); b = W'($urandom); cin_init = 1'($urandom_range(0, 1));
    start = 1'b1;
    while (completed < 500 && cyc < 6000) begin
      idle_now = !busy;
      exp_now  = model(a, b, cin_init);
      tick();
      cyc++;
      if (idle_now && start) begin
        exp_q.push_back(exp_now);
        accepted++;
        if (accepted == 500) start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin_init = 1'($urandom_range(0, 1));
      end
      if (done) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_done: cycle %0d, no job outstanding", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            n_fail++;
            $display("FAIL b2b_result job %0d: got %h expected %h", completed, {cout, sum}, e);
          end
        end
        if (last_done >= 0) begin
          n_tests++;
          if (cyc - last_done !== GAP) begin
            n_fail++;
            $display("FAIL b2b_spacing job %0d: got %0d cycles expected %0d",
                     completed, cyc - last_done, GAP);
          end
        end
        last_done = cyc;
        completed++;
      end
    end
    start = 1'b0;
    n_tests++;
    if (completed !== 500) begin
      n_fail++;
      $display("FAIL b2b_completed: got %0d jobs expected 500 (cycle budget %0d)",
               completed, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_start_while_busy();
    test_reset_mid_job();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
